// File: rtl/shift_left_sequencer.sv
// shift_left_sequencer: multi-cycle 16-bit left shifter using a base-3 stage decomposition.
// The 4-bit shift amount is split into digits d2,d1,d0 (amt = d0 + 3*d1 + 9*d2, each 0..2).
// Each stage k then shifts by d_k*3^k, one stage per cycle. Handshakes use valid/ready on both sides.
// Optional feature macro: SHIFT_ROTATE_EN. When it is defined, a captured Rotate=1 makes every
// stage rotate left instead of filling, so the net result is a rotate-left by the amount.
// Without the macro, Rotate is ignored and no rotate logic is built.
module shift_left_sequencer #(
  parameter int   SKIP_ZERO_STAGES = 0,
  parameter logic FILL_BIT         = 1'b0
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [15:0] InData,
  input  logic [3:0]  InAmt,
  input  logic        Rotate,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [15:0] OutData,
  output logic [5:0]  OutDigits
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ENC  = 3'd1,
    S_ST0  = 3'd2,
    S_ST1  = 3'd3,
    S_ST2  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic SKIP = (SKIP_ZERO_STAGES != 0);

  // Base-3 encoding of a 0..15 amount into {d2,d1,d0}, 2 bits per digit.
  function automatic logic [5:0] enc_base3(input logic [3:0] amt);
    logic [1:0] d2;
    logic [1:0] d1;
    logic [3:0] rem;
    logic [3:0] rem2;
    if (amt >= 4'd9) begin
      d2  = 2'd1;
      rem = amt - 4'd9;
    end else begin
      d2  = 2'd0;
      rem = amt;
    end
    if (rem >= 4'd6) begin
      d1   = 2'd2;
      rem2 = rem - 4'd6;
    end else if (rem >= 4'd3) begin
      d1   = 2'd1;
      rem2 = rem - 4'd3;
    end else begin
      d1   = 2'd0;
      rem2 = rem;
    end
    return {d2, d1, 2'(rem2)};
  endfunction

  // Shift distance of stage k for digit d: d * 3^k, at most 18.
  function automatic logic [4:0] stage_amt(input logic [1:0] k, input logic [1:0] d);
    logic [4:0] w;
    logic [4:0] res;
    case (k)
      2'd0:    w = 5'd1;
      2'd1:    w = 5'd3;
      default: w = 5'd9;
    endcase
    case (d)
      2'd1:    res = w;
      2'd2:    res = {w[3:0], 1'b0};
      default: res = 5'd0;
    endcase
    return res;
  endfunction

  // Logical left shift with FILL_BIT in vacated LSBs; 16 or more clears to all FILL_BIT.
  function automatic logic [15:0] shl_fill(input logic [15:0] d, input logic [4:0] sh);
    logic [31:0] t;
    logic [15:0] res;
    if (sh >= 5'd16) begin
      res = {16{FILL_BIT}};
    end else begin
      t   = {d, {16{FILL_BIT}}} << sh;
      res = t[31:16];
    end
    return res;
  endfunction

`ifdef SHIFT_ROTATE_EN
  // Rotate left by sh mod 16.
  function automatic logic [15:0] rotl16(input logic [15:0] d, input logic [4:0] sh);
    logic [31:0] t;
    t = {d, d} << sh[3:0];
    return t[31:16];
  endfunction
`endif

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_work;
  logic [3:0]  r_amt;
  logic [5:0]  r_digits;
  logic [15:0] r_out_data;
  logic        r_out_valid;
  logic        r_in_ready;
  logic [5:0]  w_enc;
  logic [1:0]  w_stage_k;
  logic [1:0]  w_stage_digit;
  logic        w_in_stage;
  logic [4:0]  w_stage_sh;
  logic [15:0] w_stage_res;
  logic [15:0] w_final;
  logic        w_accept;

`ifdef SHIFT_ROTATE_EN
  logic        r_rot;
`else
  logic        w_unused_rotate;
  assign w_unused_rotate = Rotate;
`endif

  assign InReady   = r_in_ready;
  assign OutValid  = r_out_valid;
  assign OutData   = r_out_data;
  assign OutDigits = r_digits;

  assign w_enc    = enc_base3(r_amt);
  assign w_accept = InValid && (r_state == S_IDLE);

  // Select the digit and weight index of the stage currently executing.
  always_comb begin
    w_stage_k     = 2'd0;
    w_stage_digit = 2'd0;
    w_in_stage    = 1'b0;
    case (r_state)
      S_ST0: begin
        w_stage_k     = 2'd0;
        w_stage_digit = r_digits[1:0];
        w_in_stage    = 1'b1;
      end
      S_ST1: begin
        w_stage_k     = 2'd1;
        w_stage_digit = r_digits[3:2];
        w_in_stage    = 1'b1;
      end
      S_ST2: begin
        w_stage_k     = 2'd2;
        w_stage_digit = r_digits[5:4];
        w_in_stage    = 1'b1;
      end
      default: begin
        w_stage_k     = 2'd0;
        w_stage_digit = 2'd0;
        w_in_stage    = 1'b0;
      end
    endcase
  end

  assign w_stage_sh = stage_amt(w_stage_k, w_stage_digit);

`ifdef SHIFT_ROTATE_EN
  // Stage result: rotate when the captured request asked for it, otherwise fill.
  always_comb begin
    w_stage_res = 16'h0000;
    if (r_rot) begin
      w_stage_res = rotl16(r_work, w_stage_sh);
    end else begin
      w_stage_res = shl_fill(r_work, w_stage_sh);
    end
  end
`else
  assign w_stage_res = shl_fill(r_work, w_stage_sh);
`endif

  // Value published on OutData when entering DONE (ENC can jump straight there for amount 0).
  always_comb begin
    w_final = r_work;
    if (w_in_stage) begin
      w_final = w_stage_res;
    end else begin
      w_final = r_work;
    end
  end

  // Next-state logic; with skipping, zero-digit stages are bypassed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_ENC;
        else          w_next = S_IDLE;
      end
      S_ENC: begin
        if (!SKIP)                   w_next = S_ST0;
        else if (w_enc[1:0] != 2'd0) w_next = S_ST0;
        else if (w_enc[3:2] != 2'd0) w_next = S_ST1;
        else if (w_enc[5:4] != 2'd0) w_next = S_ST2;
        else                         w_next = S_DONE;
      end
      S_ST0: begin
        if (!SKIP)                      w_next = S_ST1;
        else if (r_digits[3:2] != 2'd0) w_next = S_ST1;
        else if (r_digits[5:4] != 2'd0) w_next = S_ST2;
        else                            w_next = S_DONE;
      end
      S_ST1: begin
        if (!SKIP)                      w_next = S_ST2;
        else if (r_digits[5:4] != 2'd0) w_next = S_ST2;
        else                            w_next = S_DONE;
      end
      S_ST2: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        if (OutReady) w_next = S_IDLE;
        else          w_next = S_DONE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Working datapath: capture the request, then apply one stage per cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_work <= 16'h0000;
      r_amt  <= 4'd0;
`ifdef SHIFT_ROTATE_EN
      r_rot  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_work <= InData;
      r_amt  <= InAmt;
`ifdef SHIFT_ROTATE_EN
      r_rot  <= Rotate;
`endif
    end else if (w_in_stage) begin
      r_work <= w_stage_res;
    end
  end

  // Digits are registered once per request, in ENC, and held until the next ENC.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                r_digits <= 6'd0;
    else if (r_state == S_ENC) r_digits <= w_enc;
  end

  // Registered handshake flags and result, so outputs never depend on input timing.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_data  <= 16'h0000;
    end else begin
      r_out_valid <= (w_next == S_DONE);
      r_in_ready  <= (w_next == S_IDLE);
      if ((r_state != S_DONE) && (w_next == S_DONE)) begin
        r_out_data <= w_final;
      end
    end
  end

endmodule

// File: tb/tb_shift_left_sequencer.sv
// Directed bench for shift_left_sequencer: one fixed-latency and one stage-skipping instance.
module tb_shift_left_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic        rotate;
  logic        out_ready;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [15:0] out_data  [2];
  logic [5:0]  out_digits[2];

  int n_cmp = 0;
  int n_err = 0;

`ifdef SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic [5:0]  dig;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];

  shift_left_sequencer #(.SKIP_ZERO_STAGES(0)) u_fix (
    .Clk(clk), .Rst_n(rst_n), .InValid(in_valid[0]), .InReady(in_ready[0]),
    .InData(in_data), .InAmt(in_amt), .Rotate(rotate), .OutValid(out_valid[0]),
    .OutReady(out_ready), .OutData(out_data[0]), .OutDigits(out_digits[0])
  );

  shift_left_sequencer #(.SKIP_ZERO_STAGES(1)) u_skip (
    .Clk(clk), .Rst_n(rst_n), .InValid(in_valid[1]), .InReady(in_ready[1]),
    .InData(in_data), .InAmt(in_amt), .Rotate(rotate), .OutValid(out_valid[1]),
    .OutReady(out_ready), .OutData(out_data[1]), .OutDigits(out_digits[1])
  );

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  function automatic logic [5:0] model_digits(input logic [3:0] a);
    int v, d2, d1, d0;
    v  = int'(a);
    d2 = v / 9;
    v  = v - 9 * d2;
    d1 = v / 3;
    d0 = v - 3 * d1;
    return 6'(d2 * 16 + d1 * 4 + d0);
  endfunction

  function automatic logic [15:0] model_data(input logic [15:0] d, input logic [3:0] a, input logic r);
    logic [15:0] sh;
    logic [15:0] wrap;
    sh   = d << a;
    wrap = d >> (5'd16 - {1'b0, a});
    if (r && ROT_EN) return sh | wrap;
    return sh;
  endfunction

  task automatic run_req(input int sel, input logic [15:0] d, input logic [3:0] a, input logic r, input string tag);
    exp_t e;
    exp_t got;
    int   lat;
    e.dig  = model_digits(a);
    e.data = model_data(d, a, r);
    if (sel == 0) e.lat = 32'd4;
    else e.lat = 32'(1 + int'(e.dig[1:0] != 2'd0) + int'(e.dig[3:2] != 2'd0) + int'(e.dig[5:4] != 2'd0));
    @(negedge clk);
    check(tag, "in_ready_before", 32'(in_ready[sel]), 32'd1);
    in_data = d; in_amt = a; rotate = r; out_ready = 1'b1;
    in_valid[sel] = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    #1 in_valid[sel] = 1'b0;
    lat = 0;
    while (lat < 12) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid[sel]) break;
    end
    got = sb.pop_front();
    check(tag, "latency", 32'(lat), got.lat);
    check(tag, "out_data", 32'(out_data[sel]), 32'(got.data));
    check(tag, "out_digits", 32'(out_digits[sel]), 32'(got.dig));
    @(posedge clk);
    #1;
    check(tag, "out_valid_after", 32'(out_valid[sel]), 32'd0);
    check(tag, "in_ready_after", 32'(in_ready[sel]), 32'd1);
  endtask

  initial begin
    exp_t e;
    int   lat;
    rst_n = 1'b0;
    in_data = 16'h0000; in_amt = 4'd0; rotate = 1'b0; out_ready = 1'b1;
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", "in_ready", 32'(in_ready[0]), 32'd1);
    check("reset", "out_valid", 32'(out_valid[0]), 32'd0);
    check("reset", "out_data", 32'(out_data[0]), 32'd0);
    check("reset", "out_digits", 32'(out_digits[0]), 32'd0);
    rst_n = 1'b1;

    // Main function and spec examples on both instances.
    run_req(0, 16'h0001, 4'd15, 1'b0, "t1_fix");
    run_req(1, 16'h0001, 4'd15, 1'b0, "t1_skip");
    run_req(0, 16'h00FF, 4'd5,  1'b0, "t2_fix");
    run_req(1, 16'h00FF, 4'd5,  1'b0, "t2_skip");
    run_req(0, 16'hA5A5, 4'd0,  1'b0, "t3_fix");
    run_req(1, 16'hA5A5, 4'd0,  1'b0, "t3_skip");
    run_req(1, 16'h0003, 4'd14, 1'b0, "t14_skip");
    run_req(0, 16'h8001, 4'd1,  1'b1, "t6a_fix");
    run_req(0, 16'h0001, 4'd13, 1'b1, "t6b_fix");
    run_req(1, 16'h8001, 4'd1,  1'b1, "t6c_skip");
    run_req(1, 16'hC3A5, 4'd12, 1'b1, "t6d_skip");
    for (int i = 0; i < 16; i++) begin
      run_req(i % 2, 16'($urandom), 4'(i), 1'(i / 2), "sweep");
    end

    // Backpressure in DONE with stray InValid.
    e.dig = model_digits(4'd4);
    e.data = model_data(16'h0F0F, 4'd4, 1'b0);
    e.lat = 32'd4;
    @(negedge clk);
    in_data = 16'h0F0F; in_amt = 4'd4; rotate = 1'b0; out_ready = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk);
    sb.push_back(e);
    #1 in_valid[0] = 1'b0;
    lat = 0;
    while (lat < 12) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid[0]) break;
    end
    e = sb.pop_front();
    check("bp", "latency", 32'(lat), e.lat);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid[0] = 1'b1; in_data = 16'hFFFF; in_amt = 4'd3;
      check("bp", "out_valid_held", 32'(out_valid[0]), 32'd1);
      check("bp", "in_ready_low", 32'(in_ready[0]), 32'd0);
      check("bp", "out_data_held", 32'(out_data[0]), 32'(e.data));
      check("bp", "out_digits_held", 32'(out_digits[0]), 32'(e.dig));
    end
    @(negedge clk);
    in_valid[0] = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp", "out_valid_released", 32'(out_valid[0]), 32'd0);
    check("bp", "in_ready_released", 32'(in_ready[0]), 32'd1);
    check("bp", "out_data_idle", 32'(out_data[0]), 32'(e.data));
    @(posedge clk);
    #1;
    check("bp", "no_queued_request", 32'(in_ready[0]), 32'd1);

    // Asynchronous reset while the fixed instance is in ST1.
    @(negedge clk);
    in_data = 16'h1111; in_amt = 4'd15; rotate = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid", "out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_mid", "in_ready", 32'(in_ready[0]), 32'd1);
    check("rst_mid", "out_data", 32'(out_data[0]), 32'd0);
    check("rst_mid", "out_digits", 32'(out_digits[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid", "no_output", 32'(out_valid[0]), 32'd0);
    run_req(0, 16'h0003, 4'd2, 1'b0, "t5_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
